// File: rtl/mem_access_ctrl.sv
// Memory-access stage controller: accepts one execute-stage instruction at a time,
// runs its data-memory access with an ack timeout, and produces writeback/branch pulses.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  // Handshake: an instruction transfers on any rising edge where ex_valid & ex_ready;
  // ex_ready depends only on FSM state, so it never combinationally follows ex_valid.
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [63:0] ex_branch_addr,
  input  logic        ex_zero,
  input  logic        ex_b,
  input  logic        ex_bz,
  input  logic        ex_bnz,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        pc_src,
  output logic [63:0] pc_target,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [63:0] alu_q, sd_q, br_q;
  logic        zero_q, b_q, bz_q, bnz_q, mr_q, mw_q, m2r_q, rw_q;
  logic [4:0]  rd_q;

  logic accept, is_mem, bad_mem, ex_take, lat_take, timeout_hit;

  assign ex_ready    = (state_q == IDLE);
  assign accept      = ex_valid & ex_ready;
  assign is_mem      = ex_mem_read | ex_mem_write;
  assign bad_mem     = is_mem & ((ex_alu_result[2:0] != 3'b000) | (ex_mem_read & ex_mem_write));
  assign ex_take     = ex_b | (ex_bz & ex_zero) | (ex_bnz & ~ex_zero);
  assign lat_take    = b_q | (bz_q & zero_q) | (bnz_q & ~zero_q);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // The request bus is driven straight from the latched instruction, so it is stable for the whole access.
  assign dmem_addr  = alu_q;
  assign dmem_wdata = sd_q;
  assign dmem_we    = mw_q & ~mr_q;
  assign wb_rd      = rd_q;
  assign pc_target  = br_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_mem) state_d = bad_mem ? RESP : ACCESS;
      ACCESS:  if (dmem_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_q  <= '0;
      sd_q   <= '0;
      br_q   <= '0;
      zero_q <= 1'b0;
      b_q    <= 1'b0;
      bz_q   <= 1'b0;
      bnz_q  <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
      rd_q   <= '0;
    end else if (accept) begin
      alu_q  <= ex_alu_result;
      sd_q   <= ex_store_data;
      br_q   <= ex_branch_addr;
      zero_q <= ex_zero;
      b_q    <= ex_b;
      bz_q   <= ex_bz;
      bnz_q  <= ex_bnz;
      mr_q   <= ex_mem_read;
      mw_q   <= ex_mem_write;
      m2r_q  <= ex_mem_to_reg;
      rw_q   <= ex_reg_write;
      rd_q   <= ex_rd;
    end
  end

  // Writeback and branch pulses are loaded on the edge that enters RESP (or that accepts an
  // ALU op), so they are high for exactly one cycle and never depend combinationally on ex_*.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      pc_src       <= 1'b0;
      mem_err      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      wb_valid <= 1'b0;
      pc_src   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_mem || bad_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_reg_write <= ex_reg_write & ~is_mem;
              pc_src       <= ex_take;
              if (bad_mem) mem_err <= 1'b1;
            end else begin
              dmem_req <= 1'b1;
              cnt_q    <= '0;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            cnt_q        <= '0;
            wb_valid     <= 1'b1;
            wb_data      <= m2r_q ? dmem_rdata : alu_q;
            wb_reg_write <= rw_q & ~mw_q;
            pc_src       <= lat_take;
          end else if (timeout_hit) begin
            dmem_req     <= 1'b0;
            cnt_q        <= '0;
            mem_err      <= 1'b1;
            wb_valid     <= 1'b1;
            wb_data      <= alu_q;
            wb_reg_write <= 1'b0;
            pc_src       <= lat_take;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of instructions with expected writeback, a memory
// responder with per-op ack latency, and a scoreboard queue checked on every wb_valid.
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic        clk, reset_n;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_alu_result, ex_store_data, ex_branch_addr;
  logic        ex_zero, ex_b, ex_bz, ex_bnz;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        pc_src, mem_err;
  logic [63:0] pc_target;
  logic [1:0]  dbg_state;

  typedef struct packed {
    logic [63:0] alu, sd, br;
    logic        zero, b, bz, bnz, mr, mw, m2r, rw;
    logic [4:0]  rd;
    logic [7:0]  lat;          // ack on this req cycle; 0 = never ack
    logic [63:0] rdata;
    logic [63:0] e_data;
    logic        e_chk_data, e_rw, e_pc, e_err;
    logic [7:0]  e_req;        // expected number of dmem_req cycles
  } vec_t;

  typedef struct packed {
    logic [63:0] data, target;
    logic        chk_data, rw, pc, err;
    logic [4:0]  rd;
    logic [7:0]  req;
  } exp_t;

  vec_t  vt[$];
  vec_t  v, cur;
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    total, bad, req_cnt, waited;
  logic  err_model, stray, prev_alu;

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_branch_addr(ex_branch_addr),
    .ex_zero(ex_zero), .ex_b(ex_b), .ex_bz(ex_bz), .ex_bnz(ex_bnz),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_src(pc_src), .pc_target(pc_target), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // driver: present one instruction, wait (bounded) for ex_ready, transfer on the next edge
  task automatic issue(input vec_t iv, output int n);
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!ex_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) begin
      chk("issue_ready_timeout", ex_ready, 1);
    end else begin
      cur            = iv;
      ex_valid       = 1'b1;
      ex_alu_result  = iv.alu;
      ex_store_data  = iv.sd;
      ex_branch_addr = iv.br;
      ex_zero        = iv.zero;
      ex_b           = iv.b;
      ex_bz          = iv.bz;
      ex_bnz         = iv.bnz;
      ex_mem_read    = iv.mr;
      ex_mem_write   = iv.mw;
      ex_mem_to_reg  = iv.m2r;
      ex_reg_write   = iv.rw;
      ex_rd          = iv.rd;
      e.data     = iv.e_data;
      e.target   = iv.br;
      e.chk_data = iv.e_chk_data;
      e.rw       = iv.e_rw;
      e.pc       = iv.e_pc;
      e.err      = iv.e_err;
      e.rd       = iv.rd;
      e.req      = iv.e_req;
      exp_q.push_back(e);
      @(posedge clk);
      #1 ex_valid = 1'b0;
    end
  endtask

  // memory responder + scoreboard monitor, all sampled on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      req_cnt    = 0;
      dmem_ack   = 1'b0;
    end else begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb", wb_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          err_model = err_model | mon_e.err;
          chk("wb_reg_write", wb_reg_write, mon_e.rw);
          chk("wb_rd", wb_rd, mon_e.rd);
          if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
          chk("pc_src", pc_src, mon_e.pc);
          if (mon_e.pc) chk("pc_target", pc_target, mon_e.target);
          chk("mem_err", mem_err, err_model);
          chk("req_cycles", req_cnt, mon_e.req);
        end
        req_cnt = 0;
      end else begin
        chk("pc_src_alone", pc_src, 0);
      end
      if (dmem_req) begin
        req_cnt++;
        chk("req_addr", dmem_addr, cur.alu);
        chk("req_we", dmem_we, cur.mw);
        chk("req_wdata", dmem_wdata, cur.sd);
        chk("req_ready_low", ex_ready, 0);
      end
      dmem_ack   = (dmem_req && req_cnt == int'(cur.lat)) || stray;
      dmem_rdata = dmem_ack ? cur.rdata : {$urandom, $urandom};
    end
  end

  initial begin
    total = 0; bad = 0; req_cnt = 0; err_model = 1'b0; stray = 1'b0; cur = '0;
    reset_n = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    ex_alu_result = '0; ex_store_data = '0; ex_branch_addr = '0; ex_zero = 1'b0;
    ex_b = 1'b0; ex_bz = 1'b0; ex_bnz = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;

    // vector table
    v = '0; v.alu = 64'h2A; v.rd = 5'd3; v.rw = 1; v.e_data = 64'h2A; v.e_chk_data = 1; v.e_rw = 1; vt.push_back(v);
    v = '0; v.alu = 64'h77; v.rd = 5'd5; v.b = 1; v.br = 64'h200; v.e_data = 64'h77; v.e_chk_data = 1; v.e_pc = 1; vt.push_back(v);
    v = '0; v.alu = 64'h100; v.mr = 1; v.m2r = 1; v.rw = 1; v.rd = 5'd7; v.lat = 3; v.rdata = 64'hDEADBEEF;
    v.e_data = 64'hDEADBEEF; v.e_chk_data = 1; v.e_rw = 1; v.e_req = 3; vt.push_back(v);
    v = '0; v.alu = 64'h108; v.sd = 64'h55; v.mw = 1; v.rd = 5'd2; v.lat = 2;
    v.e_data = 64'h108; v.e_chk_data = 1; v.e_req = 2; vt.push_back(v);
    v = '0; v.alu = 64'h110; v.sd = 64'hA5A5; v.mw = 1; v.rw = 1; v.rd = 5'd9; v.lat = 1;
    v.e_data = 64'h110; v.e_chk_data = 1; v.e_req = 1; vt.push_back(v);
    v = '0; v.alu = 64'h103; v.mr = 1; v.m2r = 1; v.rw = 1; v.rd = 5'd4; v.lat = 1; v.e_err = 1; vt.push_back(v);
    v = '0; v.alu = 64'h5; v.bz = 1; v.zero = 1; v.br = 64'h400; v.rd = 5'd1; v.e_data = 64'h5; v.e_chk_data = 1; v.e_pc = 1; vt.push_back(v);
    v = '0; v.alu = 64'h6; v.bnz = 1; v.zero = 1; v.br = 64'h500; v.rd = 5'd1; v.e_data = 64'h6; v.e_chk_data = 1; vt.push_back(v);
    v = '0; v.alu = 64'h7; v.bnz = 1; v.br = 64'h800; v.rd = 5'd8; v.rw = 1; v.e_data = 64'h7; v.e_chk_data = 1; v.e_rw = 1; v.e_pc = 1; vt.push_back(v);
    v = '0; v.alu = 64'h200; v.mr = 1; v.m2r = 1; v.rw = 1; v.rd = 5'd6; v.lat = 0; v.e_err = 1; v.e_req = 8'(TMO); vt.push_back(v);
    v = '0; v.alu = 64'h208; v.mr = 1; v.mw = 1; v.rw = 1; v.rd = 5'd6; v.e_err = 1; vt.push_back(v);
    v = '0; v.alu = 64'h300; v.mr = 1; v.rw = 1; v.rd = 5'd10; v.lat = 1; v.rdata = 64'hFFFF;
    v.e_data = 64'h300; v.e_chk_data = 1; v.e_rw = 1; v.e_req = 1; vt.push_back(v);
    v = '0; v.alu = 64'h99; v.rd = 5'd11; v.rw = 1; v.e_data = 64'h99; v.e_chk_data = 1; v.e_rw = 1; vt.push_back(v);
    v = '0; v.alu = 64'h310; v.mr = 1; v.m2r = 1; v.rw = 1; v.rd = 5'd12; v.bz = 1; v.br = 64'h900; v.lat = 4;
    v.rdata = 64'h1234; v.e_data = 64'h1234; v.e_chk_data = 1; v.e_rw = 1; v.e_req = 4; vt.push_back(v);
    v = '0; v.alu = 64'h318; v.mr = 1; v.m2r = 1; v.rw = 1; v.rd = 5'd13; v.b = 1; v.br = 64'hA00; v.lat = 1;
    v.rdata = 64'hCAFE; v.e_data = 64'hCAFE; v.e_chk_data = 1; v.e_rw = 1; v.e_pc = 1; v.e_req = 1; vt.push_back(v);
    for (int i = 0; i < 6; i++) begin
      v = '0;
      v.alu = {32'($urandom), 32'($urandom)};
      v.rd  = 5'($urandom_range(0, 31));
      v.rw  = 1'($urandom_range(0, 1));
      v.e_data = v.alu; v.e_chk_data = 1; v.e_rw = v.rw;
      vt.push_back(v);
    end

    // reset state, forced while reset_n is low
    #3;
    chk("rst_ready", ex_ready, 1);
    chk("rst_state", dbg_state, 0);
    chk("rst_outs", {dmem_req, dmem_we, wb_valid, wb_reg_write, pc_src, mem_err}, 0);
    chk("rst_buses", dmem_addr | dmem_wdata | wb_data | pc_target | 64'(wb_rd), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // table-driven run; an ALU op must let the next op in on the very next cycle
    prev_alu = 1'b0;
    foreach (vt[i]) begin
      issue(vt[i], waited);
      if (prev_alu) chk("b2b_wait", waited, 0);
      prev_alu = !(vt[i].mr || vt[i].mw);
    end

    // drain, bounded
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);

    // stray ack while idle is ignored
    @(negedge clk); stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_state", dbg_state, 0);
    chk("stray_req", dmem_req, 0);

    // reset in the middle of an access abandons it
    v = '0; v.alu = 64'h400; v.mr = 1; v.m2r = 1; v.rw = 1; v.rd = 5'd14; v.lat = 0;
    issue(v, waited);
    repeat (3) @(negedge clk);
    chk("pre_rst_req", dmem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_err", mem_err, 0);
    chk("midrst_state", dbg_state, 0);
    exp_q.delete();
    err_model = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_ready", ex_ready, 1);

    // operation resumes after reset
    v = '0; v.alu = 64'h2A; v.rd = 5'd3; v.rw = 1; v.e_data = 64'h2A; v.e_chk_data = 1; v.e_rw = 1;
    issue(v, waited);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
